fp_round_pack: RTL and testbench
================================

# fp_round_pack

Rounding and packing stage of the pipelined FP multiplier. It sits directly downstream of the normalisation stage. It takes the normalised 48-bit product, the sign and an overflow-safe exponent, and rounds to single or half precision under the selected rounding mode. It then detects overflow and underflow, merges the special-case override and emits the packed result with flags. It is a 2-stage valid/ready pipeline with full throughput.

## Interface
- Parameters: none.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `valid_in` in 1: upstream item valid.
- `ready_out` out 1: stage can accept; `!r1_valid || r2_ready`.
- `ready_in` in 1: downstream ready.
- `valid_out` out 1: `result`/`flags` valid.
- `mode_fp` in 1: 0 = half, 1 = single. Sampled with the item.
- `round_mode` in 1: 0 = round-nearest-even (RNE), 1 = round-toward-zero (RTZ). Sampled with the item.
- `sign` in 1: product sign.
- `exp_norm` in 10: two's-complement exponent, single bias 127 in both modes; half operands arrive pre-rebiased by +112.
- `mant_norm` in 48: normalised product, hidden bit at [46]; bit [47] is always 0.
- `spec_override` in 1: bypass rounding and emit `spec_result`/`spec_flags` unchanged.
- `spec_result` in 32; `spec_flags` in 5.
- `result` out 32: packed result; half results occupy [15:0] with [31:16]=0.
- `flags` out 5: [4] DZ (always 0), [3] NV, [2] OF, [1] UF, [0] NX.

## Operation
- Stage R1 (round decision) registers sign, mode, override fields and the decision values below.
  - Single: keep = mant[46:23] (24b), G = mant[22], S = |mant[21:0].
  - Half: keep = mant[46:36] (11b), G = mant[35], S = |mant[34:0].
  - `inc` = RNE ? G & (S | keep[0]) : 0. `inexact` = G | S.
  - R1 registers keep+inc (1 extra carry bit), `exp_norm`, `inexact` and the override fields.
- Stage R2 (fixup and pack).
  - Mantissa carry: if the rounded value is 2^24 (single) or 2^11 (half), the mantissa becomes 1.0 and the exponent increments by 1.
  - Half exponent = exp − 112; single exponent = exp. E_MAX is 254 for single and 30 for half.
  - Underflow (exp ≤ 0 before rounding): flush to signed zero; flags UF|NX. No subnormal output.
  - Overflow (exp > E_MAX after carry): RNE gives signed inf (7F800000 / 7C00), RTZ gives signed max finite (7F7FFFFF / 7BFF). Flags OF|NX.
  - Otherwise, pack {sign, exp[7:0] or exp[4:0], fraction without the hidden bit}; flags = NX if inexact.
  - With `spec_override`=1, result and flags come from the spec inputs; rounding logic is ignored.
- Each register stage uses the codebase handshake.
  - Load when `valid_in && ready_out` (per stage).
  - Clear valid when `valid && ready_in` with no new load.
  - Data holds while stalled.

## Timing
- Latency 2 cycles from an accepted input to `valid_out`. Throughput 1 item/cycle with `ready_in`=1.
- `ready_out` is combinational from R2 state and `ready_in`; it has no combinational path from `valid_in`.
- Stall: `result`/`flags` are stable while `valid_out && !ready_in`. Items are never dropped or duplicated. The pipeline can hold 2 items.
- A simultaneous accept and drain in the same cycle is legal in both stages.
- Reset (any cycle, including mid-stall) sets `valid_out`=0, `result`=0, `flags`=0 and both internal valids to 0. In-flight items are discarded. `ready_out`=1 the cycle after reset is released.

## Structure
- Shared package: flag bit indices, `MODE_HALF`/`MODE_SINGLE`, `RND_RNE`/`RND_RTZ`, bias constants (127, 112), E_MAX values, inf/max-finite patterns for both formats.
- One sub-module: `round_pipe_reg`, a parameterised-width valid/ready register, instantiated twice.

## Test plan
- Single, exp=127, mant=48'h4000_0000_0000, RNE: result 32'h3F800000, flags 0, at exactly 2 cycles.
- Tie cases, single RNE, exp=127:
  - mant=48'h4000_0040_0000 gives 3F800000, flags 5'b00001.
  - mant=48'h4000_00C0_0000 gives 3F800002, flags 5'b00001.
  - Same first input with RTZ gives 3F800000, NX.
- Carry and overflow, mant=48'h7FFF_FFC0_0000, RNE:
  - exp=127 gives 40000000, NX.
  - exp=254 gives 7F800000, flags 5'b00101.
  - exp=255 with RTZ gives 7F7FFFFF, flags 5'b00101.
- Half and edge cases:
  - Half, exp=127, mant=1.0 gives 32'h0000_3C00.
  - exp=0, sign=1 gives 80000000, flags 5'b00011.
  - `spec_override` with spec_result=7FC00000, flags 01000 passes through unchanged.
- Backpressure and reset:
  - Stream 4 items with `ready_in` toggling every cycle: all 4 emerge in order, unchanged while stalled.
  - Assert `rst` mid-stream: `valid_out`=0 the next cycle, no stale item later.

Source files
------------

// File: rtl/fp_round_pack_pkg.sv
// Shared constants and the R1 payload layout for the FP round/pack stage.
package fp_round_pack_pkg;

    // Flag bit positions within the 5-bit flags bus
    localparam int FLAG_DZ = 4;
    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Format and rounding-mode encodings
    localparam logic MODE_HALF   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;
    localparam logic RND_RNE     = 1'b0;
    localparam logic RND_RTZ     = 1'b1;

    // Exponent bias handling: everything arrives single-biased, half is
    // rebiased by subtracting 112 (127 - 15)
    localparam int BIAS_SINGLE      = 127;
    localparam int BIAS_HALF        = 15;
    localparam int BIAS_HALF_REBIAS = BIAS_SINGLE - BIAS_HALF;

    // Largest finite biased exponent per format
    localparam int E_MAX_SINGLE = 254;
    localparam int E_MAX_HALF   = 30;

    // Saturation patterns, sign bit excluded
    localparam logic [31:0] INF_SINGLE  = 32'h7F80_0000;
    localparam logic [31:0] MAXF_SINGLE = 32'h7F7F_FFFF;
    localparam logic [15:0] INF_HALF    = 16'h7C00;
    localparam logic [15:0] MAXF_HALF   = 16'h7BFF;

    // State carried from R1 (round decision) into R2 (fixup and pack)
    typedef struct packed {
        logic        sign;
        logic        mode_fp;
        logic        round_mode;
        logic        spec_override;
        logic [31:0] spec_result;
        logic [4:0]  spec_flags;
        logic [9:0]  exp;
        logic [24:0] rounded;
        logic        inexact;
    } r1_t;

    localparam int R1_W = $bits(r1_t);
    localparam int R2_W = 37;

endpackage

// File: rtl/round_pipe_reg.sv
// One valid/ready pipeline register: loads on accept, holds while stalled,
// and allows accept and drain in the same cycle.
module round_pipe_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              vld_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;
    assign out_data  = data_q;

    // Capture on accept; drop valid when drained without a refill
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            vld_q  <= 1'b1;
            data_q <= in_data;
        end else if (out_ready) begin
            vld_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_round_pack.sv
// Rounding and packing stage of the FP multiplier: R1 makes the round
// decision, R2 applies carry/overflow/underflow fixup and packs the result.
module fp_round_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic        ready_in,
    output logic        valid_out,
    input  logic        mode_fp,
    input  logic        round_mode,
    input  logic        sign,
    input  logic [9:0]  exp_norm,
    input  logic [47:0] mant_norm,
    input  logic        spec_override,
    input  logic [31:0] spec_result,
    input  logic [4:0]  spec_flags,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    import fp_round_pack_pkg::*;

    // Returns {keep + inc (25b, carry in [24]), inexact}
    function automatic logic [25:0] round_decide(input logic [47:0] mant,
                                                 input logic        mode,
                                                 input logic        rmode);
        logic [23:0] keep;
        logic        g;
        logic        s;
        logic        inc;
        logic [24:0] rounded;
        if (mode == MODE_SINGLE) begin
            keep = mant[46:23];
            g    = mant[22];
            s    = |mant[21:0];
        end else begin
            keep = {13'd0, mant[46:36]};
            g    = mant[35];
            s    = |mant[34:0];
        end
        inc     = (rmode == RND_RNE) ? (g & (s | keep[0])) : 1'b0;
        rounded = {1'b0, keep} + {24'd0, inc};
        return {rounded, g | s};
    endfunction

    // Returns {result, flags} after carry fixup, saturation and flush
    function automatic logic [36:0] pack_result(input r1_t d);
        logic signed [10:0] e_fmt;
        logic signed [10:0] e_adj;
        logic signed [10:0] e_max;
        logic               carry;
        logic [22:0]        frac;
        logic [31:0]        res;
        logic [4:0]         flg;
        res = '0;
        flg = '0;
        if (d.mode_fp == MODE_SINGLE) begin
            e_fmt = {d.exp[9], d.exp};
            carry = d.rounded[24];
            frac  = carry ? 23'd0 : d.rounded[22:0];
            e_max = 11'(E_MAX_SINGLE);
        end else begin
            e_fmt = {d.exp[9], d.exp} - 11'(BIAS_HALF_REBIAS);
            carry = d.rounded[11];
            frac  = carry ? 23'd0 : {13'd0, d.rounded[9:0]};
            e_max = 11'(E_MAX_HALF);
        end
        // A rounding carry renormalises to 1.0 and bumps the exponent
        e_adj = carry ? (e_fmt + 11'sd1) : e_fmt;

        if (d.spec_override) begin
            res = d.spec_result;
            flg = d.spec_flags;
        end else if (e_fmt <= 11'sd0) begin
            // No subnormal output: flush to signed zero
            res = (d.mode_fp == MODE_SINGLE) ? {d.sign, 31'd0}
                                             : {16'd0, d.sign, 15'd0};
            flg[FLAG_UF] = 1'b1;
            flg[FLAG_NX] = 1'b1;
        end else if (e_adj > e_max) begin
            // RNE saturates to infinity, RTZ to the largest finite value
            if (d.mode_fp == MODE_SINGLE)
                res = {d.sign, (d.round_mode == RND_RTZ) ? MAXF_SINGLE[30:0] : INF_SINGLE[30:0]};
            else
                res = {16'd0, d.sign, (d.round_mode == RND_RTZ) ? MAXF_HALF[14:0] : INF_HALF[14:0]};
            flg[FLAG_OF] = 1'b1;
            flg[FLAG_NX] = 1'b1;
        end else begin
            if (d.mode_fp == MODE_SINGLE)
                res = {d.sign, e_adj[7:0], frac};
            else
                res = {16'd0, d.sign, e_adj[4:0], frac[9:0]};
            flg[FLAG_NX] = d.inexact;
        end
        return {res, flg};
    endfunction

    r1_t             r1_d_p0;
    r1_t             r1_q_p1;
    logic            vld_p1;
    logic            r2_ready;
    logic [R2_W-1:0] r2_d_p1;
    logic [R2_W-1:0] r2_q_p2;
    logic [25:0]     rnd_p0;
    logic            unused_bits;

    // ---- stage R1: round decision on the incoming item ----
    // Assemble the R1 payload from the inputs and the round decision
    always_comb begin
        rnd_p0                = round_decide(mant_norm, mode_fp, round_mode);
        r1_d_p0               = '0;
        r1_d_p0.sign          = sign;
        r1_d_p0.mode_fp       = mode_fp;
        r1_d_p0.round_mode    = round_mode;
        r1_d_p0.spec_override = spec_override;
        r1_d_p0.spec_result   = spec_result;
        r1_d_p0.spec_flags    = spec_flags;
        r1_d_p0.exp           = exp_norm;
        r1_d_p0.rounded       = rnd_p0[25:1];
        r1_d_p0.inexact       = rnd_p0[0];
    end

    round_pipe_reg #(.DATA_W(R1_W)) u_r1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (valid_in),
        .in_ready  (ready_out),
        .in_data   (r1_d_p0),
        .out_valid (vld_p1),
        .out_ready (r2_ready),
        .out_data  (r1_q_p1)
    );

    // ---- stage R2: fixup, saturation and packing ----
    // Compute the packed result from the registered round decision
    always_comb begin
        r2_d_p1 = pack_result(r1_q_p1);
    end

    round_pipe_reg #(.DATA_W(R2_W)) u_r2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (vld_p1),
        .in_ready  (r2_ready),
        .in_data   (r2_d_p1),
        .out_valid (valid_out),
        .out_ready (ready_in),
        .out_data  (r2_q_p2)
    );

    assign result = r2_q_p2[36:5];
    assign flags  = r2_q_p2[4:0];

    // mant_norm[47] is always zero and the hidden bit needs no storage
    assign unused_bits = ^{mant_norm[47], r1_q_p1.rounded[23]};

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed cases, randomized traffic
// against an arithmetic reference model, backpressure and mid-stream reset.
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic        ready_in = 1'b1;
    logic        valid_out;
    logic        mode_fp = 1'b1;
    logic        round_mode = 1'b0;
    logic        sign = 1'b0;
    logic [9:0]  exp_norm = '0;
    logic [47:0] mant_norm = '0;
    logic        spec_override = 1'b0;
    logic [31:0] spec_result = '0;
    logic [4:0]  spec_flags = '0;
    logic [31:0] result;
    logic [4:0]  flags;

    fp_round_pack dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .ready_in      (ready_in),
        .valid_out     (valid_out),
        .mode_fp       (mode_fp),
        .round_mode    (round_mode),
        .sign          (sign),
        .exp_norm      (exp_norm),
        .mant_norm     (mant_norm),
        .spec_override (spec_override),
        .spec_result   (spec_result),
        .spec_flags    (spec_flags),
        .result        (result),
        .flags         (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [36:0] v;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          toggle = 1'b0;
    bit          last_acc = 1'b0;
    bit          hold_v = 1'b0;
    logic [36:0] hold_d = '0;
    logic [36:0] pend_v = '0;

    // Reference: rounding by integer quotient/remainder on the mantissa value
    function automatic logic [36:0] model(input logic sgn, input logic md, input logic rm,
                                          input logic [9:0] e, input logic [47:0] m);
        longint unsigned mv, q, rem, halfw, one, frac, res;
        int sh, p, emax, ex;
        mv   = 64'(m);
        sh   = md ? 23 : 36;
        p    = md ? 24 : 11;
        emax = md ? 254 : 30;
        ex   = int'($signed(e));
        if (!md) ex = ex - 112;
        q     = mv >> sh;
        rem   = mv - (q << sh);
        halfw = 64'd1 << (sh - 1);
        if (ex <= 0) begin
            res = 64'(sgn) << (md ? 31 : 15);
            return {res[31:0], 5'b00011};
        end
        if (!rm && (rem > halfw || (rem == halfw && q[0]))) q = q + 1;
        one = 64'd1 << (p - 1);
        if (q == (one << 1)) begin
            q  = q >> 1;
            ex = ex + 1;
        end
        if (ex > emax) begin
            if (md) res = rm ? 64'h7F7F_FFFF : 64'h7F80_0000;
            else    res = rm ? 64'h7BFF : 64'h7C00;
            res = res | (64'(sgn) << (md ? 31 : 15));
            return {res[31:0], 5'b00101};
        end
        frac = q - one;
        res  = (64'(sgn) << (md ? 31 : 15)) + (64'(ex) << (md ? 23 : 10)) + frac;
        return {res[31:0], 4'b0000, (rem != 0)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: sample at the falling edge, then advance past the rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc = 1'b0;
        if (!rst) begin
            if (hold_v) begin
                chk("stall_valid", 64'(valid_out), 64'd1);
                chk("stall_data", 64'({result, flags}), 64'(hold_d));
            end
            if (valid_out && ready_in) begin
                n_cmp++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out: observed %h expected none", {result, flags});
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("result_flags", 64'({result, flags}), 64'(e.v));
                    if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd2);
                end
            end
            hold_v = valid_out && !ready_in;
            hold_d = {result, flags};
            if (valid_in && ready_out) begin
                e.v   = pend_v;
                e.acc = cyc;
                e.lat = !toggle;
                sb.push_back(e);
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (toggle) ready_in = !ready_in;
    endtask

    task automatic send(input logic sgn, input logic md, input logic rm, input logic [9:0] e,
                        input logic [47:0] m, input logic ov, input logic [31:0] sr,
                        input logic [4:0] sf, input logic [36:0] expv);
        sign = sgn; mode_fp = md; round_mode = rm; exp_norm = e; mant_norm = m;
        spec_override = ov; spec_result = sr; spec_flags = sf;
        pend_v = expv;
        valid_in = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_acc) break;
        end
        n_cmp++;
        assert (last_acc) else begin
            n_fail++;
            $error("FAIL accept_timeout: observed not accepted expected accepted");
        end
        valid_in = 1'b0;
    endtask

    task automatic send_rand(input logic md);
        logic [63:0] r64;
        logic [47:0] m;
        logic [9:0]  e;
        logic        sgn, rm, ov;
        logic [31:0] sr;
        logic [4:0]  sf;
        int          sel;
        r64 = {$urandom, $urandom};
        m   = {2'b01, r64[45:0]};
        if ($urandom_range(0, 3) == 0) begin
            if (md) m[21:0] = '0;
            else    m[34:0] = {r64[46], 34'd0};
        end
        sel = $urandom_range(0, 7);
        if (md) begin
            if (sel == 0)      e = 10'($signed(-$urandom_range(0, 6)));
            else if (sel == 1) e = 10'($urandom_range(250, 258));
            else               e = 10'($urandom_range(1, 253));
        end else begin
            if (sel == 0)      e = 10'($urandom_range(105, 113));
            else if (sel == 1) e = 10'($urandom_range(138, 145));
            else               e = 10'($urandom_range(113, 142));
        end
        sgn = 1'($urandom);
        rm  = 1'($urandom);
        ov  = ($urandom_range(0, 7) == 0);
        sr  = $urandom;
        sf  = 5'($urandom);
        send(sgn, md, rm, e, m, ov, sr, sf, ov ? {sr, sf} : model(sgn, md, rm, e, m));
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) tick();
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: observed %0d pending expected 0", sb.size());
        end
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;
        sb.delete();
        hold_v = 1'b0;
        chk("rst_valid_out", 64'(valid_out), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_ready_out", 64'(ready_out), 64'd1);
    endtask

    initial begin
        @(posedge clk);
        do_reset();

        // Directed cases from the rounding/packing rules
        send(0, 1, 0, 10'd127, 48'h4000_0000_0000, 0, 0, 0, {32'h3F80_0000, 5'b00000});
        drain();
        send(0, 1, 0, 10'd127, 48'h4000_0040_0000, 0, 0, 0, {32'h3F80_0000, 5'b00001});
        send(0, 1, 0, 10'd127, 48'h4000_00C0_0000, 0, 0, 0, {32'h3F80_0002, 5'b00001});
        send(0, 1, 1, 10'd127, 48'h4000_0040_0000, 0, 0, 0, {32'h3F80_0000, 5'b00001});
        send(0, 1, 0, 10'd127, 48'h7FFF_FFC0_0000, 0, 0, 0, {32'h4000_0000, 5'b00001});
        send(0, 1, 0, 10'd254, 48'h7FFF_FFC0_0000, 0, 0, 0, {32'h7F80_0000, 5'b00101});
        send(0, 1, 1, 10'd255, 48'h7FFF_FFC0_0000, 0, 0, 0, {32'h7F7F_FFFF, 5'b00101});
        send(0, 0, 0, 10'd127, 48'h4000_0000_0000, 0, 0, 0, {32'h0000_3C00, 5'b00000});
        send(1, 1, 0, 10'd0,   48'h4000_0000_0000, 0, 0, 0, {32'h8000_0000, 5'b00011});
        send(0, 1, 0, 10'd127, 48'h4000_0000_0000, 1, 32'h7FC0_0000, 5'b01000,
             {32'h7FC0_0000, 5'b01000});
        send(1, 0, 0, 10'd143, 48'h4000_0000_0000, 0, 0, 0, {32'h0000_FC00, 5'b00101});
        send(0, 0, 1, 10'd143, 48'h4000_0000_0000, 0, 0, 0, {32'h0000_7BFF, 5'b00101});
        send(0, 0, 0, 10'd112, 48'h4000_0000_0000, 0, 0, 0, {32'h0000_0000, 5'b00011});
        send(0, 0, 0, 10'd142, 48'h7FF0_0000_0000, 0, 0, 0, {32'h0000_7BFF, 5'b00000});
        drain();

        // Randomized traffic at full speed, with occasional idle gaps
        for (int i = 0; i < 200; i++) begin
            send_rand(1'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();

        // Four back-to-back items with ready_in toggling every cycle
        toggle = 1'b1;
        for (int i = 0; i < 4; i++) send_rand(1'(i));
        drain();
        for (int i = 0; i < 40; i++) send_rand(1'($urandom));
        drain();

        // Reset in the middle of a stalled stream; nothing stale may emerge
        for (int i = 0; i < 3; i++) send_rand(1'b1);
        do_reset();
        toggle = 1'b0;
        ready_in = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        for (int i = 0; i < 10; i++) send_rand(1'($urandom));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
